pw_doppler_sequencer: RTL
=========================

Name: pw_doppler_sequencer

Overview:
- Pulsed-wave Doppler timing engine; directly downstream of the settings register map.
- Consumes the decoded settings (enable, TX/RX enables, frequency, gate length, four state durations) and generates the per-frame transmit burst, range gate, sample strobe and demodulator window.
- Repeats frames continuously while enabled; setting changes apply at the next frame boundary only.

Parameters:
- DW, 16, width of state duration inputs and internal duration counters
- HP_F0, 16, carrier half-period in CLK cycles for FREQUENCY=0
- HP_F1, 8, half-period for FREQUENCY=1
- HP_F2, 4, half-period for FREQUENCY=2
- HP_F3, 2, half-period for FREQUENCY=3
- BURST_CYCLES, 4, full carrier periods per transmit burst (>=1)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- ENABLE  in  1  system enable
- TX_ON  in  2  per-channel transmitter enable, [0]=TX_P, [1]=TX_N
- RX_ON  in  1  receiver enable
- FREQUENCY  in  2  carrier select
- GATE_LENGTH  in  8  range gate length, CLK cycles
- STATE0VALUE  in  DW  delay1, burst end to gate start
- STATE1VALUE  in  DW  demod window length
- STATE2VALUE  in  DW  delay2 after demod
- STATERVALUE  in  DW  retransmit wait before next burst
- TX_P  out  1  carrier, positive phase
- TX_N  out  1  carrier, negative phase
- GATE  out  1  range gate active
- SAMPLE  out  1  one-cycle strobe on last GATE cycle
- DEMOD_EN  out  1  demodulator window, gated by RX_ON
- FRAME_START  out  1  one-cycle pulse on BURST entry
- SEQ_STATE  out  3  current state encoding, for debug
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (async, RST_N low): state IDLE; all outputs 0; counters and shadow registers 0. Exit from reset is synchronous to CLK.
- States, in order: IDLE=0, BURST=1, DELAY1=2, GATE=3, DEMOD=4, DELAY2=5, RETX=6.
- IDLE -> BURST on the first edge with ENABLE=1.
- On each BURST entry, shadow-register all inputs: FREQUENCY, TX_ON, RX_ON, GATE_LENGTH and STATE*VALUE. Shadow copies hold for the whole frame; input changes mid-frame have no effect until the next BURST entry.
- Duration rule: a state with programmed value N lasts max(N,1) cycles. Zero never skips a state and never wraps.
- The counter loads N-1 on entry, decrements each cycle, and the state exits at count 0.
- BURST:
  - lasts 2*HP*BURST_CYCLES cycles, where HP is selected by the shadow FREQUENCY.
  - half-period counter starts at phase 0. TX_P=1 during the first half-period of each carrier period, TX_N=1 during the second.
  - TX_P is ANDed with shadow TX_ON[0]; TX_N is ANDed with shadow TX_ON[1].
  - TX_P and TX_N are never both 1. Both are 0 outside BURST.
- DELAY1: STATE0VALUE cycles, all strobes low.
- GATE: GATE_LENGTH cycles with GATE=1; SAMPLE=1 on its final cycle only.
- DEMOD: STATE1VALUE cycles with DEMOD_EN = shadow RX_ON.
- DELAY2: STATE2VALUE cycles.
- RETX: STATERVALUE cycles, then -> BURST (new frame, new shadow capture) if ENABLE=1, else -> IDLE.
- FRAME_START is 1 in the first BURST cycle.
- All outputs are registered, so each output changes on the same edge as the state change that causes it.
- ENABLE=0 in any non-IDLE state: abort. Next edge -> IDLE and all outputs 0, with no partial-frame completion.
- ENABLE toggled 1->0->1 within one cycle window: an abort always completes through at least one IDLE cycle before the next BURST.
- Frame length = burst + max(S0,1) + max(GL,1) + max(S1,1) + max(S2,1) + max(SR,1) cycles, exactly periodic while ENABLE is held at 1.

Decomposition:
- Shared package/defines (alongside the existing defines file): state encodings, SEQ_STATE width, and the default half-period constants.
- One natural sub-module, pw_carrier_gen: half-period counter plus period counter. Inputs are HP, BURST_CYCLES and start; outputs are phase and done. It drives TX_P/TX_N and signals the end of BURST.
- The top level holds the FSM, the shadow registers and a single shared duration down-counter.

Test Plan:
- Reset mid-frame: assert RST_N=0 during GATE -> all outputs 0 immediately (async), state IDLE; after release with ENABLE=1, FRAME_START on the next edge.
- FREQUENCY=3 (HP=2), BURST_CYCLES=4, TX_ON=3: TX_P pattern 1100 repeated 4x over 16 cycles, TX_N its complement; never both high; both 0 after BURST.
- S0=10, GL=5, S1=20, S2=3, SR=100, RX_ON=1: GATE high for cycles 11..15 after burst end, SAMPLE on cycle 15, DEMOD_EN for the following 20 cycles; FRAME_START period = 16+10+5+20+3+100 = 154 cycles.
- Zero durations: S0=GL=S1=S2=SR=0 -> each state lasts 1 cycle; SAMPLE still pulses once; period = burst+5.
- Mid-frame write: change FREQUENCY and S1 during DEMOD -> current frame unchanged; the new values apply from the next FRAME_START. TX_ON=2'b01 -> TX_N stays 0.
- ENABLE dropped during DEMOD -> IDLE next edge, DEMOD_EN and BUSY 0; RX_ON=0 frame -> DEMOD_EN never asserts while GATE and SAMPLE still do.

Source files
------------

// File: rtl/pw_doppler_sequencer_pkg.sv
// Shared types and constants for the pulsed-wave Doppler sequencer:
// state encodings, debug state width and default carrier half-periods.
package pw_doppler_sequencer_pkg;

    localparam int SEQ_STATE_W = 3;
    localparam int CW          = 16;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_BURST  = 3'd1,
        ST_DELAY1 = 3'd2,
        ST_GATE   = 3'd3,
        ST_DEMOD  = 3'd4,
        ST_DELAY2 = 3'd5,
        ST_RETX   = 3'd6
    } seq_state_t;

    localparam int HP_F0_DEF        = 16;
    localparam int HP_F1_DEF        = 8;
    localparam int HP_F2_DEF        = 4;
    localparam int HP_F3_DEF        = 2;
    localparam int BURST_CYCLES_DEF = 4;

    function automatic logic [CW-1:0] hp_select(input logic [1:0]    freq,
                                                input logic [CW-1:0] hp0,
                                                input logic [CW-1:0] hp1,
                                                input logic [CW-1:0] hp2,
                                                input logic [CW-1:0] hp3);
        case (freq)
            2'd0:    return hp0;
            2'd1:    return hp1;
            2'd2:    return hp2;
            default: return hp3;
        endcase
    endfunction

endpackage

// File: rtl/pw_doppler_sequencer_carrier.sv
// Carrier generator: half-period and period counters that produce the
// registered TX_P/TX_N burst and flag the last burst cycle.
module pw_carrier_gen
    import pw_doppler_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [CW-1:0] i_hp,
    input  logic [CW-1:0] i_burst_cycles,
    input  logic [1:0]    i_tx_on,
    output logic          o_done,
    output logic          o_tx_p,
    output logic          o_tx_n
);

    logic [CW-1:0] r_hp_cnt;
    logic [CW-1:0] r_per_cnt;
    logic          r_phase;
    logic          r_active;
    logic          r_tx_p;
    logic          r_tx_n;

    assign o_done = r_active && r_phase && (r_hp_cnt == '0) && (r_per_cnt == '0);
    assign o_tx_p = r_tx_p;
    assign o_tx_n = r_tx_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hp_cnt  <= '0;
            r_per_cnt <= '0;
            r_phase   <= 1'b0;
            r_active  <= 1'b0;
            r_tx_p    <= 1'b0;
            r_tx_n    <= 1'b0;
        end else if (i_abort) begin
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_tx_p   <= 1'b0;
            r_tx_n   <= 1'b0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_phase   <= 1'b0;
            r_hp_cnt  <= i_hp - CW'(1);
            r_per_cnt <= i_burst_cycles - CW'(1);
            r_tx_p    <= i_tx_on[0];
            r_tx_n    <= 1'b0;
        end else if (r_active) begin
            if (r_hp_cnt != '0) begin
                r_hp_cnt <= r_hp_cnt - CW'(1);
            end else begin
                r_hp_cnt <= i_hp - CW'(1);
                if (!r_phase) begin
                    r_phase <= 1'b1;
                    r_tx_p  <= 1'b0;
                    r_tx_n  <= i_tx_on[1];
                end else if (r_per_cnt == '0) begin
                    // Final half-period done: burst is over.
                    r_active <= 1'b0;
                    r_phase  <= 1'b0;
                    r_tx_p   <= 1'b0;
                    r_tx_n   <= 1'b0;
                end else begin
                    r_per_cnt <= r_per_cnt - CW'(1);
                    r_phase   <= 1'b0;
                    r_tx_p    <= i_tx_on[0];
                    r_tx_n    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pw_doppler_sequencer.sv
// Pulsed-wave Doppler frame sequencer: FSM, per-frame shadow registers and
// one shared duration counter; the burst itself comes from pw_carrier_gen.
module pw_doppler_sequencer
    import pw_doppler_sequencer_pkg::*;
#(
    parameter int DW           = 16,
    parameter int HP_F0        = HP_F0_DEF,
    parameter int HP_F1        = HP_F1_DEF,
    parameter int HP_F2        = HP_F2_DEF,
    parameter int HP_F3        = HP_F3_DEF,
    parameter int BURST_CYCLES = BURST_CYCLES_DEF
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   ENABLE,
    input  logic [1:0]             TX_ON,
    input  logic                   RX_ON,
    input  logic [1:0]             FREQUENCY,
    input  logic [7:0]             GATE_LENGTH,
    input  logic [DW-1:0]          STATE0VALUE,
    input  logic [DW-1:0]          STATE1VALUE,
    input  logic [DW-1:0]          STATE2VALUE,
    input  logic [DW-1:0]          STATERVALUE,
    output logic                   TX_P,
    output logic                   TX_N,
    output logic                   GATE,
    output logic                   SAMPLE,
    output logic                   DEMOD_EN,
    output logic                   FRAME_START,
    output logic [SEQ_STATE_W-1:0] SEQ_STATE,
    output logic                   BUSY
);

    seq_state_t    r_state;
    logic [DW-1:0] r_cnt;
    logic [1:0]    r_freq_sh;
    logic [1:0]    r_tx_on_sh;
    logic          r_rx_on_sh;
    logic [7:0]    r_gl_sh;
    logic [DW-1:0] r_s0_sh;
    logic [DW-1:0] r_s1_sh;
    logic [DW-1:0] r_s2_sh;
    logic [DW-1:0] r_sr_sh;
    logic          r_gate;
    logic          r_sample;
    logic          r_demod_en;
    logic          r_frame_start;
    logic          r_busy;

    logic          w_start;
    logic          w_abort;
    logic          w_done;
    logic [CW-1:0] w_hp;
    logic [1:0]    w_tx_on;

    // A duration of N lasts max(N,1) cycles: load N-1, saturating at zero.
    function automatic logic [DW-1:0] dur_load(input logic [DW-1:0] n);
        return (n == '0) ? '0 : n - DW'(1);
    endfunction

    assign w_start = ENABLE && ((r_state == ST_IDLE) ||
                                ((r_state == ST_RETX) && (r_cnt == '0)));
    assign w_abort = !ENABLE;

    // On the capture edge the shadows are not yet loaded, so feed the live inputs.
    assign w_hp    = hp_select(w_start ? FREQUENCY : r_freq_sh,
                               CW'(HP_F0), CW'(HP_F1), CW'(HP_F2), CW'(HP_F3));
    assign w_tx_on = w_start ? TX_ON : r_tx_on_sh;

    pw_carrier_gen u_carrier (
        .clk            (CLK),
        .rst_n          (RST_N),
        .i_start        (w_start),
        .i_abort        (w_abort),
        .i_hp           (w_hp),
        .i_burst_cycles (CW'(BURST_CYCLES)),
        .i_tx_on        (w_tx_on),
        .o_done         (w_done),
        .o_tx_p         (TX_P),
        .o_tx_n         (TX_N)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_freq_sh     <= '0;
            r_tx_on_sh    <= '0;
            r_rx_on_sh    <= 1'b0;
            r_gl_sh       <= '0;
            r_s0_sh       <= '0;
            r_s1_sh       <= '0;
            r_s2_sh       <= '0;
            r_sr_sh       <= '0;
            r_gate        <= 1'b0;
            r_sample      <= 1'b0;
            r_demod_en    <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_sample      <= 1'b0;
            if (w_abort) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_gate     <= 1'b0;
                r_demod_en <= 1'b0;
                r_busy     <= 1'b0;
            end else if (w_start) begin
                r_state       <= ST_BURST;
                r_freq_sh     <= FREQUENCY;
                r_tx_on_sh    <= TX_ON;
                r_rx_on_sh    <= RX_ON;
                r_gl_sh       <= GATE_LENGTH;
                r_s0_sh       <= STATE0VALUE;
                r_s1_sh       <= STATE1VALUE;
                r_s2_sh       <= STATE2VALUE;
                r_sr_sh       <= STATERVALUE;
                r_frame_start <= 1'b1;
                r_busy        <= 1'b1;
            end else begin
                case (r_state)
                    ST_BURST: begin
                        if (w_done) begin
                            r_state <= ST_DELAY1;
                            r_cnt   <= dur_load(r_s0_sh);
                        end
                    end
                    ST_DELAY1: begin
                        if (r_cnt == '0) begin
                            r_state  <= ST_GATE;
                            r_cnt    <= dur_load(DW'(r_gl_sh));
                            r_gate   <= 1'b1;
                            r_sample <= (r_gl_sh <= 8'd1);
                        end else begin
                            r_cnt <= r_cnt - DW'(1);
                        end
                    end
                    ST_GATE: begin
                        if (r_cnt == '0) begin
                            r_state    <= ST_DEMOD;
                            r_cnt      <= dur_load(r_s1_sh);
                            r_gate     <= 1'b0;
                            r_demod_en <= r_rx_on_sh;
                        end else begin
                            r_cnt    <= r_cnt - DW'(1);
                            r_sample <= (r_cnt == DW'(1));
                        end
                    end
                    ST_DEMOD: begin
                        if (r_cnt == '0) begin
                            r_state    <= ST_DELAY2;
                            r_cnt      <= dur_load(r_s2_sh);
                            r_demod_en <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - DW'(1);
                        end
                    end
                    ST_DELAY2: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_RETX;
                            r_cnt   <= dur_load(r_sr_sh);
                        end else begin
                            r_cnt <= r_cnt - DW'(1);
                        end
                    end
                    ST_RETX: begin
                        r_cnt <= r_cnt - DW'(1);
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign GATE        = r_gate;
    assign SAMPLE      = r_sample;
    assign DEMOD_EN    = r_demod_en;
    assign FRAME_START = r_frame_start;
    assign SEQ_STATE   = r_state;
    assign BUSY        = r_busy;

endmodule
